// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus controller: snoop result
// encodings, bus operation codes, controller state enum and the
// helper that merges two snoop results.
package snoop_pkg;

  // Per-snooper response encodings; 2'b11 is reserved and treated as HITM
  localparam logic [1:0] SNOOP_NOHIT = 2'b00;
  localparam logic [1:0] SNOOP_HIT   = 2'b01;
  localparam logic [1:0] SNOOP_HITM  = 2'b10;
  localparam logic [1:0] SNOOP_RSVD  = 2'b11;

  // Bus operation codes carried on busOp
  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] OP_RWIM       = 8'h03;
  localparam logic [7:0] OP_INVALIDATE = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COLLECT,
    ST_RESPOND
  } state_t;

  // Merge a running result with one more snooper response.
  // Bit 1 set means HITM or the reserved code, both of which win outright.
  function automatic logic [1:0] combineResult(input logic [1:0] acc,
                                               input logic [1:0] res);
    if (acc[1] || res[1]) begin
      return SNOOP_HITM;
    end else if ((acc == SNOOP_HIT) || (res == SNOOP_HIT)) begin
      return SNOOP_HIT;
    end else begin
      return SNOOP_NOHIT;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first set request at or after the
// pointer, wrapping from the top requester back to zero. Purely
// combinational; the pointer is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  logic [IDW:0] sum;
  logic         found;

  // Walk the requesters starting at the pointer and take the first one set
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      if (!found && req_i[sum[IDW-1:0]]) begin
        grant_o[sum[IDW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping bus controller: arbitrates requesters round-robin, broadcasts
// the winning operation to the snoopers, waits SNOOP_DELAY cycles,
// merges the snoop responses and returns the result to the owner.
// Optional feature: define SNOOP_STATS_EN to add saturating per-result
// counters (statNoHit, statHit, statHitm).
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter int addressSize = 32,
  parameter int NUM_REQ     = 2,
  parameter int NUM_SNOOP   = 3,
  parameter int SNOOP_DELAY = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             reqValid,
  input  logic [NUM_REQ*addressSize-1:0] reqAddr,
  input  logic [NUM_REQ*8-1:0]           reqOp,
  output logic [NUM_REQ-1:0]             reqGrant,
  output logic                           busValid,
  output logic [addressSize-1:0]         busAddr,
  output logic [7:0]                     busOp,
  input  logic [NUM_SNOOP*2-1:0]         snoopIn,
  output logic                           respValid,
  output logic [$clog2(NUM_REQ)-1:0]     respId,
  output logic [1:0]                     respResult,
`ifdef SNOOP_STATS_EN
  output logic [15:0]                    statNoHit,
  output logic [15:0]                    statHit,
  output logic [15:0]                    statHitm,
`endif
  output logic                           busy
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t                   state_q;
  logic [IDW-1:0]           ptr_q;
  logic [IDW-1:0]           idx_q;
  logic [3:0]               cnt_q;
  logic                     busValid_q;
  logic [addressSize-1:0]   busAddr_q;
  logic [7:0]               busOp_q;
  logic                     respValid_q;
  logic [IDW-1:0]           respId_q;
  logic [1:0]               respResult_q;

  logic [NUM_REQ-1:0]       arbGrant;
  logic [IDW-1:0]           winIdx_d;
  logic [IDW-1:0]           ptr_d;
  logic [addressSize-1:0]   winAddr_d;
  logic [7:0]               winOp_d;
  logic [1:0]               combined_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i   (reqValid),
    .ptr_i   (ptr_q),
    .grant_o (arbGrant)
  );

  // Turn the one-hot winner into an index and pick out its address and op
  always_comb begin
    winIdx_d  = '0;
    winAddr_d = '0;
    winOp_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbGrant[i]) begin
        winIdx_d  = IDW'(i);
        winAddr_d = reqAddr[i*addressSize +: addressSize];
        winOp_d   = reqOp[i*8 +: 8];
      end
    end
    ptr_d = (winIdx_d == IDW'(NUM_REQ-1)) ? '0 : winIdx_d + IDW'(1);
  end

  // Merge all snooper responses with HITM > HIT > NOHIT priority
  always_comb begin
    combined_d = SNOOP_NOHIT;
    for (int s = 0; s < NUM_SNOOP; s++) begin
      combined_d = combineResult(combined_d, snoopIn[2*s +: 2]);
    end
  end

  // Main controller FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      busValid_q   <= 1'b0;
      busAddr_q    <= '0;
      busOp_q      <= '0;
      respValid_q  <= 1'b0;
      respId_q     <= '0;
      respResult_q <= SNOOP_NOHIT;
    end else begin
      busValid_q  <= 1'b0;
      respValid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|reqValid) begin
            ptr_q      <= ptr_d;
            idx_q      <= winIdx_d;
            busAddr_q  <= winAddr_d;
            busOp_q    <= winOp_d;
            busValid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= 4'(SNOOP_DELAY - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_COLLECT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_COLLECT: begin
          respResult_q <= combined_d;
          respId_q     <= idx_q;
          respValid_q  <= 1'b1;
          state_q      <= ST_RESPOND;
        end
        ST_RESPOND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant is decided in the IDLE cycle itself so the requester sees it there
  assign reqGrant   = ((state_q == ST_IDLE) && rst_n) ? arbGrant : '0;
  assign busValid   = busValid_q;
  assign busAddr    = busAddr_q;
  assign busOp      = busOp_q;
  assign respValid  = respValid_q;
  assign respId     = respId_q;
  assign respResult = respResult_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef SNOOP_STATS_EN
  logic [15:0] statNoHit_q;
  logic [15:0] statHit_q;
  logic [15:0] statHitm_q;

  // Count each delivered result by class, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statNoHit_q <= '0;
      statHit_q   <= '0;
      statHitm_q  <= '0;
    end else if (state_q == ST_RESPOND) begin
      case (respResult_q)
        SNOOP_NOHIT: if (statNoHit_q != 16'hFFFF) statNoHit_q <= statNoHit_q + 16'd1;
        SNOOP_HIT:   if (statHit_q   != 16'hFFFF) statHit_q   <= statHit_q   + 16'd1;
        default:     if (statHitm_q  != 16'hFFFF) statHitm_q  <= statHitm_q  + 16'd1;
      endcase
    end
  end

  assign statNoHit = statNoHit_q;
  assign statHit   = statHit_q;
  assign statHitm  = statHitm_q;
`endif

endmodule

// File: doc/snoop_bus_controller.md
SNOOP_BUS_CONTROLLER -- requirements
Module: snoop_bus_controller

Interface
REQ-001 SHALL have parameter addressSize, default 32, meaning bus address width.
REQ-002 SHALL have parameter NUM_REQ, default 2, meaning number of requesters (legal 2..8).
REQ-003 SHALL have parameter NUM_SNOOP, default 3, meaning number of snooping caches.
REQ-004 SHALL have parameter SNOOP_DELAY, default 2, meaning wait cycles between bus issue and snoop sampling (legal 1..15).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 reqValid  input  NUM_REQ  per-requester request, held until granted.
REQ-008 reqAddr  input  NUM_REQ*addressSize  packed per-requester address.
REQ-009 reqOp  input  NUM_REQ*8  packed per-requester bus operation code.
REQ-010 reqGrant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 busValid  output  1  bus operation strobe, one cycle.
REQ-012 busAddr  output  addressSize  address driven to snoopers.
REQ-013 busOp  output  8  operation driven to snoopers.
REQ-014 snoopIn  input  NUM_SNOOP*2  packed snoop results (00 NOHIT, 01 HIT, 10 HITM, 11 reserved).
REQ-015 respValid  output  1  one-cycle result strobe.
REQ-016 respId  output  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-017 respResult  output  2  combined snoop result.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, COLLECT, RESPOND.
REQ-020 IDLE: any reqValid -> pulse reqGrant for the round-robin winner, latch its address/op/index, go to ISSUE.
REQ-021 Round-robin: pointer=0 after reset; winner = first set reqValid at or after pointer, wrapping NUM_REQ-1 -> 0; after a grant to i, pointer = (i+1) mod NUM_REQ.
REQ-022 ISSUE: busValid=1 for exactly one cycle with the latched busAddr/busOp, then WAIT.
REQ-023 WAIT: counter loaded with SNOOP_DELAY-1 and decremented to 0; then COLLECT.
REQ-024 COLLECT: sample snoopIn once; combine with priority HITM > HIT > NOHIT; reserved 11 counts as HITM; then RESPOND.
REQ-025 RESPOND: respValid=1, respId=latched index, respResult=combined value for one cycle; next state IDLE.
REQ-026 Latency: grant cycle to respValid = SNOOP_DELAY+3 cycles; the earliest following grant is the cycle after RESPOND.
REQ-027 reqValid changes outside IDLE SHALL be ignored; a requester dropping reqValid before grant is not served.
REQ-028 busAddr/busOp SHALL hold their last value outside ISSUE; respResult/respId SHALL hold their last value outside RESPOND.

Reset
REQ-029 Asserting rst_n low in any state SHALL immediately force IDLE, pointer 0, reqGrant 0, busValid 0, respValid 0, busAddr 0, busOp 0, respId 0, respResult 00, busy 0; the in-flight operation is dropped with no response.

Configuration
REQ-030 SNOOP_STATS_EN defined: add outputs statNoHit, statHit, statHitm (16 bits each), incremented in RESPOND per result, saturating at 16'hFFFF and cleared by reset; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-031 Shared package snoop_pkg SHALL hold the snoop result encodings, bus op codes (READ, WRITE, RWIM, INVALIDATE) and the state enum.
REQ-032 Round-robin selection SHALL be one sub-module, rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-033 Single request: reqValid=01, reqAddr0=32'h1000_0008, all snoopers 01 -> busValid with busAddr 32'h1000_0008, respValid 5 cycles after grant, respId 0, respResult 01.
REQ-034 Priority combine: snoopIn = {00,01,10} -> respResult 10; all 00 -> 00; any 11 -> 10.
REQ-035 Fairness: both requesters held high for 4 operations -> grant order 0,1,0,1.
REQ-036 Pointer wrap (NUM_REQ=3): grant 2 then requests 0 and 2 both high -> next grant 0.
REQ-037 Reset in WAIT: rst_n low -> busy 0 and no respValid; after release, a new request completes normally with respId correct.
REQ-038 SNOOP_STATS_EN: 3 HITM operations -> statHitm 3; preload counter near saturation -> holds 16'hFFFF.
